// File: rtl/counter_mod_updown_if.sv
// Bus bundle for counter_mod_updown: control/load inputs and count/status outputs.
// The master side (bench or a sibling stage) drives the controls; the counter is the slave.
interface counter_mod_updown_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             carry_in;
  logic             up_down;
  logic             saturate;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count_M;
  logic             carry_out_M;
  logic             at_limit;
  logic             load_error;

  modport master (
    output enable, carry_in, up_down, saturate, load, load_value,
    input  count_M, carry_out_M, at_limit, load_error
  );

  modport slave (
    input  enable, carry_in, up_down, saturate, load, load_value,
    output count_M, carry_out_M, at_limit, load_error
  );
endinterface

// File: rtl/counter_mod_updown.sv
// Parametrised modulo-M up/down counter with range-checked parallel load,
// saturate mode and a combinational cascade carry for chaining digit stages.
// count_M and load_error are registered; at_limit and carry_out_M follow the
// current count and inputs combinationally so a chain wraps on a single edge.
module counter_mod_updown #(
  parameter int WIDTH = 4,
  parameter int M     = 10
) (
  input  logic                 clk,
  input  logic                 Reset,
  counter_mod_updown_if.slave  bus
);

  // Terminal value when counting up; M-1 always fits because M <= 2^WIDTH.
  localparam logic [WIDTH-1:0] TERM_UP  = WIDTH'(M - 1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  // Modulus held one bit wider so M = 2^WIDTH is representable.
  localparam logic [WIDTH:0]   M_EXT    = (WIDTH + 1)'(M);

  logic [WIDTH-1:0] count_r;
  logic             load_error_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             load_error_nxt_s;
  logic             step_s;
  logic [WIDTH-1:0] terminal_s;
  logic             at_term_s;
  logic             load_in_range_s;

  // Range check kept as a helper so the load path reads as intent.
  function automatic logic in_range(input logic [WIDTH-1:0] value);
    in_range = ({1'b0, value} < M_EXT);
  endfunction

  assign step_s          = bus.enable & bus.carry_in;
  assign terminal_s      = bus.up_down ? TERM_UP : ZERO;
  assign at_term_s       = (count_r == terminal_s);
  assign load_in_range_s = in_range(bus.load_value);

  // Next-state selection: load beats stepping; terminal steps wrap or hold.
  always_comb begin
    count_nxt_s      = count_r;
    load_error_nxt_s = 1'b0;
    if (bus.load) begin
      if (load_in_range_s) begin
        count_nxt_s      = bus.load_value;
        load_error_nxt_s = 1'b0;
      end else begin
        count_nxt_s      = TERM_UP;
        load_error_nxt_s = 1'b1;
      end
    end else if (step_s) begin
      if (!at_term_s) begin
        count_nxt_s = bus.up_down ? (count_r + ONE) : (count_r - ONE);
      end else if (!bus.saturate) begin
        count_nxt_s = bus.up_down ? ZERO : TERM_UP;
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      count_r      <= ZERO;
      load_error_r <= 1'b0;
    end else begin
      count_r      <= count_nxt_s;
      load_error_r <= load_error_nxt_s;
    end
  end

  // Status outputs are gated by Reset immediately, even between edges.
  assign bus.count_M     = count_r;
  assign bus.load_error  = load_error_r;
  assign bus.at_limit    = Reset & at_term_s;
  assign bus.carry_out_M = Reset & step_s & ~bus.load & ~bus.saturate & at_term_s;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Self-checking bench for counter_mod_updown (WIDTH=4, M=10): a vector table
// with a scoreboard queue for registered results, plus a two-stage BCD cascade.
module tb_counter_mod_updown;

  logic clk;
  logic Reset;

  counter_mod_updown_if #(.WIDTH(4)) u_if ();
  counter_mod_updown_if #(.WIDTH(4)) t_if ();

  counter_mod_updown #(.WIDTH(4), .M(10)) u_units (
    .clk   (clk),
    .Reset (Reset),
    .bus   (u_if.slave)
  );

  counter_mod_updown #(.WIDTH(4), .M(10)) u_tens (
    .clk   (clk),
    .Reset (Reset),
    .bus   (t_if.slave)
  );

  // Tens stage is enabled by the units wrap carry.
  assign t_if.carry_in = u_if.carry_out_M;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, ci, ud, sat, ld;
    logic [3:0] lv;
    logic       exp_carry, exp_lim;
    logic [3:0] exp_cnt;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [3:0] cnt;
    logic       err;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [7:0]  sb_bcd[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic ci, input logic ud,
                     input logic sat, input logic ld, input logic [3:0] lv,
                     input logic ec, input logic el, input logic [3:0] cnt, input logic err);
    vec_t v;
    v.rst = rst; v.en = en; v.ci = ci; v.ud = ud; v.sat = sat; v.ld = ld; v.lv = lv;
    v.exp_carry = ec; v.exp_lim = el; v.exp_cnt = cnt; v.exp_err = err;
    vecs.push_back(v);
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    Reset           = v.rst;
    u_if.enable     = v.en;
    u_if.carry_in   = v.ci;
    u_if.up_down    = v.ud;
    u_if.saturate   = v.sat;
    u_if.load       = v.ld;
    u_if.load_value = v.lv;
    #1;
    check($sformatf("vec%0d carry_out_M", idx), {31'd0, u_if.carry_out_M}, {31'd0, v.exp_carry});
    check($sformatf("vec%0d at_limit", idx), {31'd0, u_if.at_limit}, {31'd0, v.exp_lim});
    e.cnt = v.exp_cnt;
    e.err = v.exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check($sformatf("vec%0d count_M", idx), {28'd0, u_if.count_M}, {28'd0, got.cnt});
    check($sformatf("vec%0d load_error", idx), {31'd0, u_if.load_error}, {31'd0, got.err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    u_if.enable = 1'b0; u_if.carry_in = 1'b1; u_if.up_down = 1'b1;
    u_if.saturate = 1'b0; u_if.load = 1'b0; u_if.load_value = 4'd0;
    t_if.enable = 1'b0; t_if.up_down = 1'b1; t_if.saturate = 1'b0;
    t_if.load = 1'b0; t_if.load_value = 4'd0;

    // rst en ci ud sat ld lv | carry lim | count err
    // Reset held 3 edges with enable and load active
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  1'b0, 1'b0, 4'd0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 4'd0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 4'd0, 1'b0);
    // Up count 0..9 then wrap
    for (int k = 0; k < 10; k++)
      add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'(k == 9), 1'(k == 9), 4'((k + 1) % 10), 1'b0);
    // Down wrap 0 -> 9 -> 8, then direction switches at 9
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0);
    // Loads: in range, out of range, one-cycle error, load beats a wrap, boundaries
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 4'd7, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 4'd9, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd9, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  1'b0, 1'b1, 4'd2, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 4'd9, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9,  1'b0, 1'b1, 4'd9, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 4'd9, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1, 4'd0, 1'b0);
    // Saturate up: climb to 9, hold 5 edges, then step down
    for (int k = 0; k < 9; k++)
      add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'(k + 1), 1'b0);
    for (int k = 0; k < 5; k++)
      add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b0);
    // Saturate down at 0
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0);
    // carry_in low blocks stepping, including at terminal
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0);
    // Mid-operation reset with load, then 4 hold edges
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    // Reset clears a pending load_error
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 4'd9, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++)
      apply(i, vecs[i]);

    // Cascade: units -> tens, 100 edges from 00
    Reset = 1'b0;
    u_if.load = 1'b0; u_if.saturate = 1'b0; u_if.up_down = 1'b1;
    u_if.enable = 1'b1; u_if.carry_in = 1'b1;
    t_if.enable = 1'b1;
    @(posedge clk);
    #1;
    Reset = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      logic [7:0] exp_bcd;
      logic [7:0] got_bcd;
      exp_bcd = {4'(((e / 10) % 10)), 4'((e % 10))};
      sb_bcd.push_back(exp_bcd);
      if (e == 100) begin
        #1;
        check("cascade units carry at 99", {31'd0, u_if.carry_out_M}, 32'd1);
        check("cascade tens carry at 99", {31'd0, t_if.carry_out_M}, 32'd1);
      end
      @(posedge clk);
      #1;
      got_bcd = sb_bcd.pop_front();
      check($sformatf("cascade edge %0d", e), {24'd0, t_if.count_M, u_if.count_M}, {24'd0, got_bcd});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_mod_updown.md
# counter_mod_updown

Parametrised modulo-M counter, the next generation of the fixed 4-bit modulo counter. It adds configurable width and modulus, up/down direction, synchronous parallel load with range checking, and a saturate mode. A combinational cascade carry in/out lets instances chain into multi-digit counters, for example BCD units/tens. It sits in the same test-circuit family and is driven directly by a testbench or by a sibling counter's carry.

## Interface
- WIDTH, 4, counter register width in bits
- M, 10, modulus; count range 0..M-1; legal 2 ≤ M ≤ 2^WIDTH
- clk  input  1  single clock, all state updates on rising edge
- Reset  input  1  synchronous, active-low reset
- enable  input  1  count enable
- carry_in  input  1  cascade enable from a lower stage; tie 1 when unused
- up_down  input  1  direction: 1 = up, 0 = down
- saturate  input  1  1 = hold at limit instead of wrapping
- load  input  1  synchronous parallel load strobe
- load_value  input  WIDTH  value to load
- count_M  output  WIDTH  current count, registered
- carry_out_M  output  1  combinational wrap indicator for cascading
- at_limit  output  1  combinational: count is at the terminal value for the current direction
- load_error  output  1  registered one-cycle pulse, out-of-range load

## Operation
- step = enable & carry_in.
- Terminal value: M-1 when up_down=1, 0 when up_down=0.
- Update priority at each rising edge of clk, highest first:
  - Reset=0: count_M ← 0, load_error ← 0.
  - load=1: count_M ← load_value if load_value < M, else M-1. load_error ← (load_value ≥ M). Load ignores enable, carry_in and saturate.
  - step=1, count not at terminal: count_M ← count_M ± 1.
  - step=1, count at terminal, saturate=0: wrap. Up gives M-1 → 0; down gives 0 → M-1.
  - step=1, count at terminal, saturate=1: hold.
  - Otherwise: hold.
- load_error ← 0 on any edge without an out-of-range load.
- at_limit = Reset & (count_M == terminal value).
- carry_out_M = Reset & step & ~load & ~saturate & at_limit. It is high exactly in the cycle whose edge produces a wrap.
- Arithmetic is modulo M, never modulo 2^WIDTH. count_M never holds a value ≥ M.
- Direction may change on any cycle. The terminal value and the outputs follow up_down combinationally.

## Timing
- Reset values: count_M = 0, load_error = 0. carry_out_M and at_limit are forced 0 while Reset=0.
- Reset is sampled only on the clk edge. An asynchronous Reset transition changes no output until the next edge, except the combinational gating of carry_out_M and at_limit.
- Load latency: count_M shows the loaded value one cycle after load is sampled. load_error is valid in that same cycle.
- Count latency: one cycle per step.
- carry_out_M has zero-cycle latency. A downstream stage sees it as carry_in before the same edge, so an N-stage chain wraps all stages on one edge.
- Simultaneous events:
  - Reset with load: reset wins.
  - load with step: load wins, and carry_out_M = 0.
  - saturate with a terminal step: hold, and carry_out_M = 0.
- Reset mid-operation: state clears on the next edge regardless of count, direction or load.

## Test plan
- Reset and up-count (M=10): Reset=0 for 3 edges with enable=1 and load=1 → count_M=0, carry_out_M=0, at_limit=0. Release with up_down=1 and run 10 edges → 1,2,…,9,0. carry_out_M=1 only while count_M=9.
- Down-count wrap: from 0 with up_down=0 and enable=1 → carry_out_M=1 at 0. Next edge gives 9, then 8. Switching up_down at count 9 makes at_limit follow in the same cycle.
- Load: load_value=7 → count_M=7 next cycle, load_error=0. load_value=12 → count_M=9, load_error=1 for exactly one cycle. load together with enable at count 9 → load wins, no wrap.
- Saturate: saturate=1 counting up → stops at 9, at_limit=1, carry_out_M=0, holds over 5 edges. Then up_down=0 → 8.
- Cascade: units carry_out_M drives tens carry_in, both M=10, enable=1, 100 edges from 00 → tens increments once per 10 edges. State reads 99 at edge 99 and 00 at edge 100, with units and tens wrapping on the same edge.
- Mid-operation reset and hold: at count 5, drive Reset=0 with load=1 for 1 edge → count_M=0, load_error=0. Then enable=0 or carry_in=0 for 4 edges → count_M holds at 0.
